// File: rtl/cdec8_seq.sv
// rtl/cdec8_seq.sv - CDEC8 microsequencer (fetch/decode/operand/execute)
// Optional single-step hold state enabled by defining CDEC8_SINGLE_STEP_EN.
module cdec8_seq #(
  parameter logic [4:0] ALU_THRU = 5'h00,
  parameter logic [4:0] ALU_INC  = 5'h01,
  parameter logic [1:0] ALU_GRP  = 2'b10,
  parameter logic [2:0] DST_NULL = 3'b110
) (
  input  logic        clock,
  input  logic        reset_N,
  input  logic [7:0]  I,
  input  logic [2:0]  SZCy,
  input  logic        run,
`ifdef CDEC8_SINGLE_STEP_EN
  input  logic        step,
`endif
  output logic [14:0] ctrl,
  output logic [7:0]  state,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_IDLE = 4'h0, S_F0 = 4'h1, S_F1 = 4'h2, S_F2 = 4'h3, S_F3 = 4'h4,
    S_DEC  = 4'h5, S_O0 = 4'h6, S_O1 = 4'h7, S_O2 = 4'h8,
    S_E0   = 4'h9, S_E1 = 4'hA, S_E2 = 4'hB, S_STEP = 4'hE, S_HALT = 4'hF
  } st_t;

  localparam logic [2:0] X_PC = 3'd0, X_A = 3'd1, X_R = 3'd4, X_RDR = 3'd5, X_NONE = 3'd7;
  localparam logic [2:0] D_PC = 3'd0, D_A = 3'd1, D_MAR = 3'd4, D_WDR = 3'd5, D_I = 3'd7;

  // End-of-instruction target: single-step parks in STEP before the next fetch.
`ifdef CDEC8_SINGLE_STEP_EN
  localparam st_t S_NEXT = S_STEP;
`else
  localparam st_t S_NEXT = S_F0;
`endif

  st_t        st, nxt;
  logic [2:0] cls;
  logic [2:0] reg_code;
  logic       cond_bit, cond;

  assign cls      = I[7:5];
  assign reg_code = (I[1:0] == 2'b00) ? X_A : {1'b0, I[1:0]};
  assign cond     = cond_bit ^ I[2];
  assign state    = {4'h0, st};
  assign illegal  = (st == S_DEC) && (cls[2:1] == 2'b11);

  always_comb begin
    case (I[1:0])
      2'b00:   cond_bit = SZCy[2];
      2'b01:   cond_bit = SZCy[1];
      2'b10:   cond_bit = SZCy[0];
      default: cond_bit = 1'b1;
    endcase
  end

  always_comb begin
    nxt = st;
    case (st)
      S_IDLE: nxt = S_F0;
      S_F0:   nxt = S_F1;
      S_F1:   nxt = S_F2;
      S_F2:   nxt = S_F3;
      S_F3:   nxt = S_DEC;
      S_DEC: begin
        case (cls)
          3'b000:                      nxt = I[0] ? S_HALT : S_NEXT;
          3'b010:                      nxt = S_E0;
          3'b001, 3'b011, 3'b100, 3'b101: nxt = S_O0;
          default:                     nxt = S_NEXT;
        endcase
      end
      S_O0:   nxt = S_O1;
      S_O1:   nxt = S_O2;
      // Jcc resolves here; the operand has already been skipped either way.
      S_O2:   nxt = (cls == 3'b101 && !cond) ? S_NEXT : S_E0;
      S_E0:   nxt = (cls == 3'b010 || cls == 3'b011) ? S_E1 : S_NEXT;
      S_E1:   nxt = S_E2;
      S_E2:   nxt = S_NEXT;
`ifdef CDEC8_SINGLE_STEP_EN
      S_STEP: nxt = step ? S_F0 : S_STEP;
`else
      S_STEP: nxt = S_F0;
`endif
      S_HALT: nxt = run ? S_F0 : S_HALT;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      st     <= S_IDLE;
      halted <= 1'b0;
    end else begin
      st     <= nxt;
      halted <= (nxt == S_HALT);
    end
  end

  logic [1:0] mmrw;
  logic       fwr, rwr;
  logic [2:0] xdst, xsrc;
  logic [4:0] aluop;

  always_comb begin
    mmrw  = 2'b00;
    fwr   = 1'b0;
    rwr   = 1'b0;
    xdst  = DST_NULL;
    aluop = ALU_THRU;
    xsrc  = X_NONE;
    case (st)
      S_F0, S_O0: begin xsrc = X_PC; xdst = D_MAR; end
      S_F1, S_O1: begin xsrc = X_PC; aluop = ALU_INC; rwr = 1'b1; mmrw = 2'b10; end
      S_F2, S_O2: begin xsrc = X_R; xdst = D_PC; end
      S_F3:       begin xsrc = X_RDR; xdst = D_I; end
      S_E0: begin
        case (cls)
          3'b001:         begin xsrc = X_RDR; xdst = reg_code; end
          3'b010:         xsrc = reg_code;
          3'b011:         begin xsrc = X_RDR; xdst = D_MAR; end
          3'b100, 3'b101: begin xsrc = X_RDR; xdst = D_PC; end
          default: ;
        endcase
      end
      S_E1: begin
        if (cls == 3'b010) begin
          xsrc = X_A; aluop = {ALU_GRP, I[4:2]}; rwr = 1'b1; fwr = 1'b1;
        end else if (cls == 3'b011) begin
          xsrc = X_A; xdst = D_WDR;
        end
      end
      S_E2: begin
        if (cls == 3'b010) begin
          xsrc = X_R; xdst = D_A;
        end else if (cls == 3'b011) begin
          mmrw = 2'b01;
        end
      end
      default: ;
    endcase
  end

  assign ctrl = {mmrw, fwr, rwr, xdst, aluop, xsrc};

endmodule

// File: tb/tb_cdec8_seq.sv
// tb/tb_cdec8_seq.sv - self-checking bench for cdec8_seq with a small datapath and ISA model
module tb_cdec8_seq;
  localparam logic [14:0] CTRL_NULL = {2'b00, 1'b0, 1'b0, 3'b110, 5'h00, 3'b111};

  logic        clock = 1'b0;
  logic        reset_N = 1'b0;
  logic        run = 1'b0;
  logic [7:0]  I_reg;
  logic [2:0]  flg;
  logic [14:0] ctrl;
  logic [7:0]  state;
  logic        halted, illegal;
`ifdef CDEC8_SINGLE_STEP_EN
  logic        step = 1'b1;
`endif
  int total = 0;
  int bad = 0;

  cdec8_seq dut (
    .clock(clock), .reset_N(reset_N), .I(I_reg), .SZCy(flg), .run(run),
`ifdef CDEC8_SINGLE_STEP_EN
    .step(step),
`endif
    .ctrl(ctrl), .state(state), .halted(halted), .illegal(illegal)
  );

  always #5 clock = ~clock;

  // Datapath driven by ctrl
  logic [7:0] pc, a, b, c, r, t, mar, wdr, rdr, xbus;
  logic [8:0] au;
  logic [7:0] mem [256];
  logic [7:0] pmem [256];
  logic [7:0] emem [256];
  logic       ld = 1'b0;
  logic [7:0] ld_a, ld_b, ld_c;
  logic [2:0] ld_f;
  logic [1:0] mmrw;
  logic       fwr, rwr;
  logic [2:0] xdst, xsrc;
  logic [4:0] aluop;
  assign {mmrw, fwr, rwr, xdst, aluop, xsrc} = ctrl;

  function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
    case (op)
      3'd0:    alu_f = {1'b0, x} + {1'b0, y};
      3'd1:    alu_f = {1'b0, x} - {1'b0, y};
      3'd2:    alu_f = {1'b0, x & y};
      3'd3:    alu_f = {1'b0, x | y};
      3'd4:    alu_f = {1'b0, x ^ y};
      default: alu_f = {1'b0, ~x};
    endcase
  endfunction

  always_comb begin
    case (xsrc)
      3'd0:    xbus = pc;
      3'd1:    xbus = a;
      3'd2:    xbus = b;
      3'd3:    xbus = c;
      3'd4:    xbus = r;
      3'd5:    xbus = rdr;
      3'd6:    xbus = {5'b0, flg};
      default: xbus = 8'h00;
    endcase
    if (aluop == 5'h01)            au = {1'b0, xbus} + 9'd1;
    else if (aluop[4:3] == 2'b10)  au = alu_f(aluop[2:0], xbus, t);
    else                           au = {1'b0, xbus};
  end

  always @(posedge clock) begin
    if (ld) begin
      pc <= 8'h00; a <= ld_a; b <= ld_b; c <= ld_c; flg <= ld_f; I_reg <= 8'h00;
      r <= 8'h00; t <= 8'h00; mar <= 8'h00; wdr <= 8'h00; rdr <= 8'h00;
      for (int k = 0; k < 256; k++) mem[8'(k)] <= pmem[8'(k)];
    end else begin
      if (rwr) r <= au[7:0];
      if (fwr) flg <= {au[7], (au[7:0] == 8'h00), au[8]};
      case (xdst)
        3'd0: pc <= xbus;
        3'd1: a <= xbus;
        3'd2: b <= xbus;
        3'd3: c <= xbus;
        3'd4: mar <= xbus;
        3'd5: wdr <= xbus;
        3'd6: t <= xbus;
        default: I_reg <= xbus;
      endcase
      if (mmrw == 2'b10) rdr <= mem[mar];
      if (mmrw == 2'b01) mem[mar] <= wdr;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Instruction-level reference: per-class cycle costs and architectural effects.
  task automatic model(input logic [7:0] a0, b0, c0, input logic [2:0] f0,
                       output int cyc, output logic [7:0] epc, ea, eb, ec, output int nill);
    logic [7:0] rg [4];
    logic [7:0] p, ins, opd;
    logic [2:0] f;
    logic [8:0] res;
    logic [1:0] rs;
    logic       tk;
    for (int k = 0; k < 256; k++) emem[8'(k)] = pmem[8'(k)];
    rg[0] = 8'h00; rg[1] = a0; rg[2] = b0; rg[3] = c0; f = f0; p = 8'h00; cyc = 0; nill = 0;
    for (int n = 0; n < 100; n++) begin
      ins = emem[p]; opd = emem[p + 8'd1]; p = p + 8'd1; cyc += 5;
      rs = (ins[1:0] == 2'b00) ? 2'd1 : ins[1:0];
      case (ins[7:5])
        3'd0: if (ins[0]) break;
        3'd1: begin rg[rs] = opd; p = p + 8'd1; cyc += 4; end
        3'd2: begin
          res = alu_f(ins[4:2], rg[1], rg[rs]);
          rg[1] = res[7:0]; f = {res[7], (res[7:0] == 8'h00), res[8]}; cyc += 3;
        end
        3'd3: begin emem[opd] = rg[1]; p = p + 8'd1; cyc += 6; end
        3'd4: begin p = opd; cyc += 4; end
        3'd5: begin
          tk = ins[2] ^ ((ins[1:0] == 2'b11) ? 1'b1 : f[2'd2 - ins[1:0]]);
          if (tk) begin p = opd; cyc += 4; end
          else    begin p = p + 8'd1; cyc += 3; end
        end
        default: nill++;
      endcase
    end
    epc = p; ea = rg[1]; eb = rg[2]; ec = rg[3];
  endtask

  task automatic start(input logic [7:0] a0, b0, c0, input logic [2:0] f0);
    @(negedge clock);
    reset_N = 1'b0; run = 1'b0;
    ld_a = a0; ld_b = b0; ld_c = c0; ld_f = f0; ld = 1'b1;
    @(negedge clock);
    ld = 1'b0; reset_N = 1'b1;
  endtask

  int          n_ill, n_wr;
  logic [7:0]  post_dec, wr_mar, wr_wdr, e1_t;
  logic [14:0] e1_ctrl;

  task automatic run_halt(output int cyc, output bit ok);
    logic [7:0] prev;
    cyc = 0; ok = 1'b0; n_ill = 0; n_wr = 0; post_dec = 8'hFF; prev = 8'h00;
    e1_ctrl = 15'h0; e1_t = 8'h00;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clock);
      if (prev == 8'h05 && post_dec == 8'hFF) post_dec = state;
      chk("mmrw_excl", 32'(mmrw == 2'b11), 32'd0);
      chk("fwr_only_alu_e1", 32'(fwr && !(state == 8'h0A && I_reg[7:5] == 3'b010)), 32'd0);
      chk("illegal_pulse", 32'(illegal), 32'(state == 8'h05 && I_reg[7:6] == 2'b11));
      if (halted) begin ok = 1'b1; break; end
      if (state != 8'h00) cyc++;
      if (illegal) n_ill++;
      if (state == 8'h0A && I_reg[7:5] == 3'b010) begin e1_ctrl = ctrl; e1_t = t; end
      if (mmrw == 2'b01) begin n_wr++; wr_mar = mar; wr_wdr = wdr; end
      prev = state;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL halt_timeout: got no halt want halted=1");
    end
  endtask

  task automatic gen_prog();
    int ni, ad;
    int cl [12];
    int adr [12];
    for (int k = 0; k < 256; k++) pmem[8'(k)] = 8'h01;
    ni = int'($urandom_range(4, 10)); ad = 0;
    for (int i = 0; i < ni; i++) begin
      cl[i] = int'($urandom_range(0, 7)); adr[i] = ad;
      ad += (cl[i] == 1 || cl[i] == 3 || cl[i] == 4 || cl[i] == 5) ? 2 : 1;
    end
    adr[ni] = ad;
    for (int i = 0; i < ni; i++) begin
      case (cl[i])
        0: pmem[8'(adr[i])] = {3'b000, 4'($urandom), 1'b0};
        1: begin pmem[8'(adr[i])] = {3'b001, 5'($urandom)}; pmem[8'(adr[i] + 1)] = 8'($urandom); end
        2: pmem[8'(adr[i])] = {3'b010, 5'($urandom)};
        3: begin pmem[8'(adr[i])] = {3'b011, 5'($urandom)}; pmem[8'(adr[i] + 1)] = 8'h80 | 8'($urandom); end
        4, 5: begin
          pmem[8'(adr[i])] = {3'(cl[i]), 5'($urandom)};
          pmem[8'(adr[i] + 1)] = 8'(adr[int'($urandom_range(i + 1, ni))]);
        end
        default: pmem[8'(adr[i])] = {3'(cl[i]), 5'($urandom)};
      endcase
    end
  endtask

  typedef struct {
    logic [7:0] ins, opd, a0, b0, c0;
    logic [2:0] f0;
    int         cyc;
    logic [7:0] pc, a;
    int         ill;
  } vec_t;

  vec_t vt [15];

  task automatic load_one(input logic [7:0] ins, input logic [7:0] opd);
    for (int k = 0; k < 256; k++) pmem[8'(k)] = 8'h01;
    pmem[0] = ins;
    if (ins[7:5] == 3'd1 || ins[7:5] == 3'd3 || ins[7:5] == 3'd4 || ins[7:5] == 3'd5) pmem[1] = opd;
  endtask

  initial begin
    int cyc, ecyc, eill, nmis;
    bit ok;
    logic [7:0] epc, ea, eb, ec, ra, rb, rc;
    logic [2:0] rf;

    vt[0]  = '{8'h21, 8'h5A, 8'h00, 8'h00, 8'h00, 3'b000, 14, 8'h03, 8'h5A, 0};
    vt[1]  = '{8'h42, 8'h00, 8'h03, 8'h04, 8'h00, 3'b000, 13, 8'h02, 8'h07, 0};
    vt[2]  = '{8'hA1, 8'h40, 8'h11, 8'h00, 8'h00, 3'b010, 14, 8'h41, 8'h11, 0};
    vt[3]  = '{8'hA1, 8'h40, 8'h11, 8'h00, 8'h00, 3'b000, 13, 8'h03, 8'h11, 0};
    vt[4]  = '{8'hA5, 8'h40, 8'h11, 8'h00, 8'h00, 3'b010, 13, 8'h03, 8'h11, 0};
    vt[5]  = '{8'hA5, 8'h40, 8'h11, 8'h00, 8'h00, 3'b000, 14, 8'h41, 8'h11, 0};
    vt[6]  = '{8'hE0, 8'h00, 8'h22, 8'h00, 8'h00, 3'b000, 10, 8'h02, 8'h22, 1};
    vt[7]  = '{8'h80, 8'h40, 8'h00, 8'h00, 8'h00, 3'b000, 14, 8'h41, 8'h00, 0};
    vt[8]  = '{8'h00, 8'h00, 8'h33, 8'h00, 8'h00, 3'b000, 10, 8'h02, 8'h33, 0};
    vt[9]  = '{8'h60, 8'h80, 8'hC3, 8'h00, 8'h00, 3'b000, 16, 8'h03, 8'hC3, 0};
    vt[10] = '{8'hA3, 8'h40, 8'h00, 8'h00, 8'h00, 3'b000, 14, 8'h41, 8'h00, 0};
    vt[11] = '{8'h20, 8'h77, 8'h00, 8'h00, 8'h00, 3'b000, 14, 8'h03, 8'h77, 0};
    vt[12] = '{8'h47, 8'h00, 8'h10, 8'h00, 8'h01, 3'b000, 13, 8'h02, 8'h0F, 0};
    vt[13] = '{8'hA2, 8'h40, 8'h00, 8'h00, 8'h00, 3'b001, 14, 8'h41, 8'h00, 0};
    vt[14] = '{8'hC4, 8'h00, 8'h44, 8'h00, 8'h00, 3'b000, 10, 8'h02, 8'h44, 1};

    // Reset state
    ld_a = 8'h00; ld_b = 8'h00; ld_c = 8'h00; ld_f = 3'b000;
    for (int k = 0; k < 256; k++) pmem[8'(k)] = 8'h01;
    ld = 1'b1;
    @(negedge clock); @(negedge clock);
    ld = 1'b0;
    chk("reset_state", 32'(state), 32'h00);
    chk("reset_ctrl", 32'(ctrl), 32'(CTRL_NULL));
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_illegal", 32'(illegal), 32'd0);

    for (int v = 0; v < 15; v++) begin
      load_one(vt[v].ins, vt[v].opd);
      start(vt[v].a0, vt[v].b0, vt[v].c0, vt[v].f0);
      run_halt(cyc, ok);
      chk($sformatf("vec%0d_cycles", v), 32'(cyc), 32'(vt[v].cyc));
      chk($sformatf("vec%0d_pc", v), 32'(pc), 32'(vt[v].pc));
      chk($sformatf("vec%0d_a", v), 32'(a), 32'(vt[v].a));
      chk($sformatf("vec%0d_illegal", v), 32'(n_ill), 32'(vt[v].ill));
    end

    // ALU E1 control word and T source
    load_one(8'h42, 8'h00);
    start(8'h03, 8'h04, 8'h00, 3'b000);
    run_halt(cyc, ok);
    chk("alu_e1_ctrl", 32'(e1_ctrl), 32'({2'b00, 1'b1, 1'b1, 3'b110, 5'b10000, 3'b001}));
    chk("alu_e1_t", 32'(e1_t), 32'h04);

    // HALT holds until run, then fetch resumes
    repeat (3) @(negedge clock);
    chk("halt_hold_state", 32'(state), 32'h0F);
    chk("halt_hold_ctrl", 32'(ctrl), 32'(CTRL_NULL));
    chk("halt_hold_halted", 32'(halted), 32'd1);
    run = 1'b1;
    @(negedge clock);
    run = 1'b0;
    chk("run_resume_state", 32'(state), 32'h01);
    chk("run_resume_halted", 32'(halted), 32'd0);

    // ST writes exactly once
    load_one(8'h60, 8'h80);
    start(8'hC3, 8'h00, 8'h00, 3'b000);
    run_halt(cyc, ok);
    chk("st_writes", 32'(n_wr), 32'd1);
    chk("st_mar", 32'(wr_mar), 32'h80);
    chk("st_wdr", 32'(wr_wdr), 32'hC3);
    chk("st_mem", 32'(mem[8'h80]), 32'hC3);

    // Illegal opcode
    load_one(8'hE0, 8'h00);
    start(8'h00, 8'h00, 8'h00, 3'b000);
    run_halt(cyc, ok);
    chk("illegal_count", 32'(n_ill), 32'd1);
    chk("illegal_next_state", 32'(post_dec), 32'h01);

    // Async reset during ST E1
    load_one(8'h60, 8'h80);
    start(8'hC3, 8'h00, 8'h00, 3'b000);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (state == 8'h0A) begin ok = 1'b1; break; end
    end
    chk("st_e1_reached", 32'(ok), 32'd1);
    #2 reset_N = 1'b0;
    #1;
    chk("async_reset_state", 32'(state), 32'h00);
    chk("async_reset_ctrl", 32'(ctrl), 32'(CTRL_NULL));
    @(negedge clock);
    chk("async_reset_nowrite", 32'(mem[8'h80]), 32'h01);

    // Random programs against the instruction-level model
    for (int n = 0; n < 40; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom); rf = 3'($urandom);
      gen_prog();
      model(ra, rb, rc, rf, ecyc, epc, ea, eb, ec, eill);
      start(ra, rb, rc, rf);
      run_halt(cyc, ok);
      chk("rnd_cycles", 32'(cyc), 32'(ecyc));
      chk("rnd_pc", 32'(pc), 32'(epc));
      chk("rnd_a", 32'(a), 32'(ea));
      chk("rnd_b", 32'(b), 32'(eb));
      chk("rnd_c", 32'(c), 32'(ec));
      chk("rnd_illegal", 32'(n_ill), 32'(eill));
      nmis = 0;
      for (int k = 0; k < 256; k++) if (mem[8'(k)] !== emem[8'(k)]) nmis++;
      chk("rnd_mem", 32'(nmis), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
